// File: rtl/trig_rx.sv
// trig_rx: trigger-link receiver with comma lock, trigger decode, sequence check and error counters
module trig_rx #(
  parameter int          LOCK_CNT = 16,
  parameter logic [15:0] COMMA    = 16'h00BC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_i,
  input  logic        kchar_i,
  input  logic        cnt_clr,
  output logic        link_up_o,
  output logic        trg_o,
  output logic [14:0] trg_num_o,
  output logic        seq_err_o,
  output logic [31:0] trg_cnt_o,
  output logic [15:0] link_err_cnt_o,
  output logic [15:0] seq_err_cnt_o
);
  typedef enum logic {LOST, UP} state_t;
  state_t      state_q, state_d;
  logic [15:0] data_q;
  logic        kchar_q;
  logic [7:0]  cc_q, cc_d;
  logic        seed_q, seed_d;
  logic        trg_q, trg_d;
  logic [14:0] num_q, num_d;
  logic        serr_q, serr_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic [15:0] lcnt_q, lcnt_d, scnt_q, scnt_d;
  logic        is_comma, is_trig, is_bad, acc, lerr, mis;
  always_comb begin
    is_comma = kchar_q && data_q == COMMA;
    is_trig  = !kchar_q && data_q[15];
    is_bad   = !is_comma && !is_trig;
    acc      = state_q == UP && is_trig;
    lerr     = state_q == UP && is_bad;
    mis      = acc && seed_q && data_q[14:0] != num_q + 15'd1;
    state_d  = state_q == LOST ? ((is_comma && cc_q == 8'(LOCK_CNT - 1)) ? UP : LOST)
                               : (is_bad ? LOST : UP);
    cc_d     = (state_q == LOST && is_comma && cc_q != 8'(LOCK_CNT - 1)) ? cc_q + 8'd1 : 8'd0;
    // expected value is only trusted once a trigger has been seen in this lock period
    seed_d   = state_q == LOST ? 1'b0 : (acc ? 1'b1 : seed_q);
    trg_d    = acc;
    num_d    = acc ? data_q[14:0] : num_q;
    serr_d   = cnt_clr ? 1'b0 : (serr_q | mis);
    tcnt_d   = cnt_clr ? 32'd0 : tcnt_q + {31'd0, acc};
    lcnt_d   = cnt_clr ? 16'd0 : ((lerr && lcnt_q != 16'hFFFF) ? lcnt_q + 16'd1 : lcnt_q);
    scnt_d   = cnt_clr ? 16'd0 : ((mis && scnt_q != 16'hFFFF) ? scnt_q + 16'd1 : scnt_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      kchar_q <= 1'b0;
      state_q <= LOST;
      cc_q    <= '0;
      seed_q  <= 1'b0;
      trg_q   <= 1'b0;
      num_q   <= '0;
      serr_q  <= 1'b0;
      tcnt_q  <= '0;
      lcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      data_q  <= data_i;
      kchar_q <= kchar_i;
      state_q <= state_d;
      cc_q    <= cc_d;
      seed_q  <= seed_d;
      trg_q   <= trg_d;
      num_q   <= num_d;
      serr_q  <= serr_d;
      tcnt_q  <= tcnt_d;
      lcnt_q  <= lcnt_d;
      scnt_q  <= scnt_d;
    end
  end
  assign link_up_o      = state_q == UP;
  assign trg_o          = trg_q;
  assign trg_num_o      = num_q;
  assign seq_err_o      = serr_q;
  assign trg_cnt_o      = tcnt_q;
  assign link_err_cnt_o = lcnt_q;
  assign seq_err_cnt_o  = scnt_q;
endmodule

// File: tb/tb_trig_rx.sv
// tb_trig_rx: directed plus randomized check of trig_rx against a word-level behavioural model
module tb_trig_rx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_i = 16'h00BC;
  logic        kchar_i = 1'b1;
  logic        cnt_clr = 1'b0;
  logic        link_up_o, trg_o, seq_err_o;
  logic [14:0] trg_num_o;
  logic [31:0] trg_cnt_o;
  logic [15:0] link_err_cnt_o, seq_err_cnt_o;
  int tests = 0, fails = 0;
  bit          m_up, m_seed, m_trg, m_serr;
  int          m_cc;
  logic [14:0] m_num;
  logic [31:0] m_tcnt;
  logic [15:0] m_lcnt, m_scnt, p_data;
  bit          p_k;
  trig_rx dut (
    .clk(clk), .rst(rst), .data_i(data_i), .kchar_i(kchar_i), .cnt_clr(cnt_clr),
    .link_up_o(link_up_o), .trg_o(trg_o), .trg_num_o(trg_num_o), .seq_err_o(seq_err_o),
    .trg_cnt_o(trg_cnt_o), .link_err_cnt_o(link_err_cnt_o), .seq_err_cnt_o(seq_err_cnt_o)
  );
  always #4 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_up = 0; m_seed = 0; m_trg = 0; m_serr = 0; m_cc = 0; m_num = 0;
    m_tcnt = 0; m_lcnt = 0; m_scnt = 0; p_data = 0; p_k = 0;
  endtask
  // one word of link traffic reaching the decision point, with cnt_clr as seen at that edge
  task automatic m_step(input logic [15:0] d, input bit k, input bit clr);
    bit comma, trig;
    comma = k && d == 16'h00BC;
    trig  = !k && d[15];
    m_trg = 0;
    if (!m_up) begin
      if (comma) begin
        m_cc++;
        if (m_cc == 16) begin m_up = 1; m_seed = 0; m_cc = 0; end
      end else m_cc = 0;
    end else if (trig) begin
      m_trg = 1;
      if (m_seed && int'(d[14:0]) != (int'(m_num) + 1) % 32768) begin
        m_serr = 1;
        if (m_scnt != 16'hFFFF) m_scnt++;
      end
      m_num = d[14:0];
      m_seed = 1;
      m_tcnt++;
    end else if (!comma) begin
      if (m_lcnt != 16'hFFFF) m_lcnt++;
      m_up = 0;
      m_cc = 0;
    end
    if (clr) begin m_tcnt = 0; m_lcnt = 0; m_scnt = 0; m_serr = 0; end
  endtask
  task automatic check_all();
    chk("link_up", {31'd0, link_up_o}, {31'd0, m_up});
    chk("trg", {31'd0, trg_o}, {31'd0, m_trg});
    chk("trg_num", {17'd0, trg_num_o}, {17'd0, m_num});
    chk("seq_err", {31'd0, seq_err_o}, {31'd0, m_serr});
    chk("trg_cnt", trg_cnt_o, m_tcnt);
    chk("link_err_cnt", {16'd0, link_err_cnt_o}, {16'd0, m_lcnt});
    chk("seq_err_cnt", {16'd0, seq_err_cnt_o}, {16'd0, m_scnt});
  endtask
  task automatic cyc(input logic [15:0] d, input bit k, input bit clr);
    data_i = d; kchar_i = k; cnt_clr = clr;
    @(posedge clk);
    m_step(p_data, p_k, clr);
    p_data = d; p_k = k;
    @(negedge clk);
    check_all();
  endtask
  task automatic commas(input int n);
    for (int i = 0; i < n; i++) cyc(16'h00BC, 1, 0);
  endtask
  initial begin
    logic [14:0] nxt;
    int r;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    check_all();
    chk("reset_link_up", {31'd0, link_up_o}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      cyc(16'h00BC, 1, 0);
      chk("lock_early", {31'd0, link_up_o}, 32'd0);
    end
    cyc(16'h00BC, 1, 0);
    chk("lock_16th_in_stage1", {31'd0, link_up_o}, 32'd0);
    cyc(16'h00BC, 1, 0);
    chk("lock_up", {31'd0, link_up_o}, 32'd1);
    chk("lock_no_trg_cnt", trg_cnt_o, 32'd0);
    cyc(16'h8005, 0, 0);
    cyc(16'h00BC, 1, 0);
    chk("trg1_strobe", {31'd0, trg_o}, 32'd1);
    cyc(16'h8006, 0, 0);
    cyc(16'h00BC, 1, 0);
    chk("trg2_strobe", {31'd0, trg_o}, 32'd1);
    chk("trg2_num", {17'd0, trg_num_o}, 32'h0006);
    chk("trg2_cnt", trg_cnt_o, 32'd2);
    chk("trg2_seq_err", {31'd0, seq_err_o}, 32'd0);
    cyc(16'hFFFF, 0, 0);
    cyc(16'h00BC, 1, 1);
    cyc(16'h8000, 0, 0);
    cyc(16'h00BC, 1, 0);
    chk("wrap_num", {17'd0, trg_num_o}, 32'h0000);
    chk("wrap_no_err", {31'd0, seq_err_o}, 32'd0);
    cyc(16'h8005, 0, 0);
    cyc(16'h00BC, 1, 0);
    chk("mis_flag", {31'd0, seq_err_o}, 32'd1);
    chk("mis_cnt", {16'd0, seq_err_cnt_o}, 32'd1);
    cyc(16'h8009, 0, 0);
    cyc(16'h00BC, 1, 1);
    chk("clr_wins_scnt", {16'd0, seq_err_cnt_o}, 32'd0);
    chk("clr_wins_serr", {31'd0, seq_err_o}, 32'd0);
    chk("clr_wins_tcnt", trg_cnt_o, 32'd0);
    cyc(16'h1234, 1, 0);
    cyc(16'h00BC, 1, 0);
    chk("loss_lcnt", {16'd0, link_err_cnt_o}, 32'd1);
    chk("loss_down", {31'd0, link_up_o}, 32'd0);
    cyc(16'h8007, 0, 0);
    cyc(16'h00BC, 1, 0);
    chk("loss_no_trg", {31'd0, trg_o}, 32'd0);
    commas(17);
    chk("relock", {31'd0, link_up_o}, 32'd1);
    cyc(16'h800F, 0, 0);
    cyc(16'h8010, 0, 0);
    chk("relock_unchecked", {31'd0, seq_err_o}, 32'd0);
    cyc(16'h8011, 0, 0);
    chk("b2b_first", {31'd0, trg_o}, 32'd1);
    cyc(16'h00BC, 1, 0);
    chk("b2b_second", {31'd0, trg_o}, 32'd1);
    chk("b2b_no_err", {31'd0, seq_err_o}, 32'd0);
    force dut.lcnt_q = 16'hFFFE;
    #1 release dut.lcnt_q;
    m_lcnt = 16'hFFFE;
    cyc(16'h0001, 0, 0);
    cyc(16'h00BC, 1, 0);
    chk("sat_reach", {16'd0, link_err_cnt_o}, 32'hFFFF);
    commas(17);
    cyc(16'h0002, 1, 0);
    cyc(16'h00BC, 1, 0);
    chk("sat_hold", {16'd0, link_err_cnt_o}, 32'hFFFF);
    commas(17);
    cyc(16'h8012, 0, 0);
    data_i = 16'h00BC; kchar_i = 1;
    @(posedge clk);
    #2 rst = 1;
    m_reset();
    #1 check_all();
    chk("rst_trg", {31'd0, trg_o}, 32'd0);
    chk("rst_link_up", {31'd0, link_up_o}, 32'd0);
    @(negedge clk);
    chk("rst_trg_held", {31'd0, trg_o}, 32'd0);
    rst = 0;
    nxt = 0;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 78) cyc(16'h00BC, 1, $urandom_range(0, 39) == 0);
      else if (r < 92) begin cyc({1'b1, nxt}, 0, $urandom_range(0, 39) == 0); nxt++; end
      else if (r < 97) cyc({1'b1, 15'($urandom)}, 0, 0);
      else cyc(16'($urandom & 32'h7FFF), $urandom_range(0, 1) == 1, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
